// File: rtl/lcd_seq_pkg.sv
// Shared types and constants for the character LCD sequencer.
// The power-on init table is only used when LCD_INIT_EN is defined.
package lcd_seq_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        LOAD,
        SETUP,
        EN,
        HOLD,
        WAIT,
        IDLE
    } state_t;

    localparam int unsigned INIT_LEN = 6;

    localparam logic [7:0] INIT_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] INIT_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] INIT_CLEAR    = 8'h01;  // clear display
    localparam logic [7:0] INIT_ENTRY    = 8'h06;  // increment, no shift

    // Clear (0x01) and home (0x02/0x03) need the long execution delay.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return (!rs) && (data[7:2] == 6'd0) && (data != 8'h00);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_seq_ctrl_init_rom.sv
// HD44780 power-on initialisation byte table (index -> command byte).
// Present only when LCD_INIT_EN is defined.
`ifdef LCD_INIT_EN
module lcd_init_rom
    import lcd_seq_pkg::*;
(
    input  logic [2:0] idx,
    output logic [7:0] data
);

    // Combinational lookup of the init command for the given step.
    always_comb begin
        case (idx)
            3'd0:    data = INIT_FUNC_SET;
            3'd1:    data = INIT_FUNC_SET;
            3'd2:    data = INIT_FUNC_SET;
            3'd3:    data = INIT_DISP_ON;
            3'd4:    data = INIT_CLEAR;
            3'd5:    data = INIT_ENTRY;
            default: data = 8'h00;
        endcase
    end

endmodule
`endif

// File: rtl/lcd_seq_ctrl.sv
// Character LCD sequencer: power-on init, then single byte writes from one
// requester with setup / enable / hold timing and command execution delay.
// Optional feature macro: LCD_INIT_EN (internal init sequence). Without it
// the controller starts in IDLE and software performs the initialisation.
module lcd_seq_ctrl
    import lcd_seq_pkg::*;
#(
    parameter int unsigned T_PWRUP    = 750000,
    parameter int unsigned T_SETUP    = 3,
    parameter int unsigned T_EN       = 12,
    parameter int unsigned T_HOLD     = 3,
    parameter int unsigned T_CMD_WAIT = 2000,
    parameter int unsigned T_CLR_WAIT = 82000
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);

    localparam int unsigned T_MAX = max_u(max_u(max_u(T_PWRUP, T_SETUP), max_u(T_EN, T_HOLD)),
                                          max_u(T_CMD_WAIT, T_CLR_WAIT));
    localparam int unsigned CNT_W = $clog2(T_MAX) + 1;

`ifdef LCD_INIT_EN
    localparam state_t           RESET_STATE = PWRUP;
    localparam logic [CNT_W-1:0] RESET_CNT   = CNT_W'(T_PWRUP - 1);
    localparam logic [2:0]       IDX_LAST    = 3'(INIT_LEN - 1);
`else
    localparam state_t           RESET_STATE = IDLE;
    localparam logic [CNT_W-1:0] RESET_CNT   = '0;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             en_q, en_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             cnt_done;

`ifdef LCD_INIT_EN
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       rom_byte;

    lcd_init_rom u_rom (
        .idx  (idx_q),
        .data (rom_byte)
    );
`endif

    assign cnt_done = (cnt_q == '0);

    // Next-state, counter and pin values; the counter is reloaded on every state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        data_d  = data_q;
        en_d    = en_q;
        ready_d = ready_q;
        done_d  = done_q;
        busy_d  = busy_q;
`ifdef LCD_INIT_EN
        idx_d   = idx_q;
`endif
        case (state_q)
`ifdef LCD_INIT_EN
            PWRUP: begin
                if (cnt_done) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            LOAD: begin
                rs_d    = 1'b0;
                data_d  = rom_byte;
                state_d = SETUP;
                cnt_d   = CNT_W'(T_SETUP - 1);
            end
`endif
            SETUP: begin
                if (cnt_done) begin
                    state_d = EN;
                    en_d    = 1'b1;
                    cnt_d   = CNT_W'(T_EN - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            EN: begin
                if (cnt_done) begin
                    state_d = HOLD;
                    en_d    = 1'b0;
                    cnt_d   = CNT_W'(T_HOLD - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_done) begin
                    state_d = WAIT;
                    cnt_d   = is_long_cmd(rs_q, data_q) ? CNT_W'(T_CLR_WAIT - 1)
                                                        : CNT_W'(T_CMD_WAIT - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WAIT: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q - CNT_W'(1);
`ifdef LCD_INIT_EN
                end else if (!done_q && (idx_q != IDX_LAST)) begin
                    // init_done low means this byte came from the init table
                    state_d = LOAD;
                    idx_d   = idx_q + 3'd1;
`endif
                end else begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            IDLE: begin
`ifndef LCD_INIT_EN
                done_d = 1'b1;
`endif
                if (req_valid && ready_q) begin
                    state_d = SETUP;
                    rs_d    = req_rs;
                    data_d  = req_data;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_W'(T_SETUP - 1);
                end else begin
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
                ready_d = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // Single state register with registered outputs; reset drops every pin at once.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q <= RESET_STATE;
            cnt_q   <= RESET_CNT;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            en_q    <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef LCD_INIT_EN
            idx_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef LCD_INIT_EN
            idx_q   <= idx_d;
`endif
        end
    end

    assign req_ready = ready_q;
    assign init_done = done_q;
    assign busy      = busy_q;
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = en_q;
    assign lcd_data  = data_q;

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Directed bench for lcd_seq_ctrl with a pulse scoreboard.
// Exercises the LCD_INIT_EN build or the default build, whichever is compiled.
module tb_lcd_seq_ctrl;

    localparam int T_PWRUP    = 20;
    localparam int T_SETUP    = 2;
    localparam int T_EN       = 4;
    localparam int T_HOLD     = 2;
    localparam int T_CMD_WAIT = 10;
    localparam int T_CLR_WAIT = 50;

    logic       clk_clk = 1'b0;
    logic       reset_reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, init_done, busy, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;

    lcd_seq_ctrl #(
        .T_PWRUP    (T_PWRUP),
        .T_SETUP    (T_SETUP),
        .T_EN       (T_EN),
        .T_HOLD     (T_HOLD),
        .T_CMD_WAIT (T_CMD_WAIT),
        .T_CLR_WAIT (T_CLR_WAIT)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .req_valid   (req_valid),
        .req_rs      (req_rs),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .init_done   (init_done),
        .busy        (busy),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_en      (lcd_en),
        .lcd_data    (lcd_data)
    );

    always #5 clk_clk = ~clk_clk;

    int cyc = 0;
    always @(posedge clk_clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         rise;
    } pulse_t;

    pulse_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int wait_cycles(input logic rs, input logic [7:0] d);
        if (rs == 1'b0 && (d == 8'h01 || d == 8'h02 || d == 8'h03))
            return T_CLR_WAIT;
        return T_CMD_WAIT;
    endfunction

    // Enable-pulse monitor: captures each pulse and checks it against the scoreboard.
    bit         prev_en = 1'b0;
    int         rise_cyc = 0;
    logic       rise_rs = 1'b0;
    logic [7:0] rise_data = 8'h00;
    pulse_t     pe;

    always @(negedge clk_clk) begin
        if (reset_reset) begin
            prev_en = 1'b0;
        end else begin
            if (lcd_en === 1'b1 && !prev_en) begin
                rise_cyc  = cyc;
                rise_rs   = lcd_rs;
                rise_data = lcd_data;
            end
            if (lcd_en === 1'b0 && prev_en) begin
                n_cmp++;
                assert (exp_q.size() > 0) else begin
                    n_bad++;
                    $error("FAIL pulse_unexpected: observed pulse data %0h at cycle %0d expected none",
                           rise_data, rise_cyc);
                end
                if (exp_q.size() > 0) begin
                    pe = exp_q.pop_front();
                    chk("pulse_rs", rise_rs, pe.rs);
                    chk("pulse_data", rise_data, pe.data);
                    chk("pulse_rise", rise_cyc, pe.rise);
                    chk("pulse_width", cyc - rise_cyc, T_EN);
                end
            end
            prev_en = (lcd_en === 1'b1);
        end
    end

    initial begin
        #200000;
        $error("FAIL watchdog: observed no finish expected finish within bound");
        $fatal(1);
    end

    task automatic release_reset(output int r0);
        reset_reset = 1'b0;
        r0 = cyc + 1;
    endtask

    // Present a byte, wait for acceptance, record the expected pulse.
    task automatic send(input logic rs, input logic [7:0] d, input bit hold, output int acc);
        pulse_t p;
        int g;
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = d;
        g = 0;
        while (req_ready !== 1'b1 && g < 1000) begin
            @(negedge clk_clk);
            g++;
        end
        chk("accept_ready", req_ready, 1'b1);
        acc    = cyc + 1;
        p.rs   = rs;
        p.data = d;
        p.rise = acc + T_SETUP;
        exp_q.push_back(p);
        @(negedge clk_clk);
        chk("ready_fall", req_ready, 1'b0);
        chk("acc_rs", lcd_rs, rs);
        chk("acc_data", lcd_data, d);
        chk("acc_busy", busy, 1'b1);
        if (!hold) req_valid = 1'b0;
    endtask

    // Wait for req_ready to return; pins must hold the accepted byte throughout.
    task automatic wait_idle(input logic rs, input logic [7:0] d, input int acc, input bit scramble);
        int g;
        bit stable;
        stable = 1'b1;
        g = 0;
        while (req_ready !== 1'b1 && g < 1000) begin
            if (scramble) req_data = 8'($urandom_range(0, 255));
            @(negedge clk_clk);
            if (lcd_rs !== rs || lcd_data !== d || lcd_rw !== 1'b0) stable = 1'b0;
            g++;
        end
        chk("ready_return", cyc, acc + T_SETUP + T_EN + T_HOLD + wait_cycles(rs, d));
        chk("pins_stable", stable, 1'b1);
        chk("idle_busy", busy, 1'b0);
    endtask

`ifdef LCD_INIT_EN
    logic [7:0] init_tbl[6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    task automatic run_init(input int r0);
        pulse_t p;
        int l, done_cyc, g;
        l = r0 + T_PWRUP;
        done_cyc = 0;
        for (int i = 0; i < 6; i++) begin
            p.rs   = 1'b0;
            p.data = init_tbl[i];
            p.rise = l + T_SETUP;
            exp_q.push_back(p);
            done_cyc = l + T_SETUP + T_EN + T_HOLD + wait_cycles(1'b0, init_tbl[i]);
            l = done_cyc + 1;
        end
        @(negedge clk_clk);
        chk("pwrup_busy", busy, 1'b0);
        chk("pwrup_done", init_done, 1'b0);
        g = 0;
        while (init_done !== 1'b1 && g < 2000) begin
            @(negedge clk_clk);
            g++;
        end
        chk("init_done_cyc", cyc, done_cyc);
        chk("init_pulses_left", exp_q.size(), 0);
        chk("init_ready", req_ready, 1'b1);
    endtask
`endif

    logic [7:0] cmds[3] = '{8'h01, 8'h02, 8'h80};

    initial begin
        int r0, acc, g;

        repeat (3) @(negedge clk_clk);
        chk("rst_en", lcd_en, 1'b0);
        chk("rst_rs", lcd_rs, 1'b0);
        chk("rst_rw", lcd_rw, 1'b0);
        chk("rst_data", lcd_data, 8'h00);
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_done", init_done, 1'b0);
        chk("rst_busy", busy, 1'b0);

        release_reset(r0);
`ifdef LCD_INIT_EN
        run_init(r0);
`else
        @(negedge clk_clk);
        chk("first_ready", req_ready, 1'b1);
        chk("first_done", init_done, 1'b1);
        chk("first_busy", busy, 1'b0);
`endif

        // data byte 0x41
        send(1'b1, 8'h41, 1'b0, acc);
        wait_idle(1'b1, 8'h41, acc, 1'b0);

        // clear, home, set-DDRAM-address commands
        for (int i = 0; i < 3; i++) begin
            send(1'b0, cmds[i], 1'b0, acc);
            wait_idle(1'b0, cmds[i], acc, 1'b0);
        end

        // valid held with changing data during the transfer
        send(1'b1, 8'h55, 1'b1, acc);
        wait_idle(1'b1, 8'h55, acc, 1'b1);
        send(1'b1, 8'h5A, 1'b0, acc);
        wait_idle(1'b1, 8'h5A, acc, 1'b0);

        // command 0x00 takes the short wait
        send(1'b0, 8'h00, 1'b0, acc);
        wait_idle(1'b0, 8'h00, acc, 1'b0);

        // reset while the enable strobe is high
        send(1'b0, 8'h80, 1'b0, acc);
        g = 0;
        while (lcd_en !== 1'b1 && g < 100) begin
            @(negedge clk_clk);
            g++;
        end
        chk("midrst_en_seen", lcd_en, 1'b1);
        reset_reset = 1'b1;
        @(negedge clk_clk);
        chk("midrst_en", lcd_en, 1'b0);
        chk("midrst_data", lcd_data, 8'h00);
        chk("midrst_rs", lcd_rs, 1'b0);
        chk("midrst_ready", req_ready, 1'b0);
        chk("midrst_done", init_done, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        exp_q.delete();
        repeat (2) @(negedge clk_clk);
        release_reset(r0);
`ifdef LCD_INIT_EN
        run_init(r0);
`else
        @(negedge clk_clk);
        chk("rerun_ready", req_ready, 1'b1);
        chk("rerun_done", init_done, 1'b1);
`endif
        send(1'b1, 8'h41, 1'b0, acc);
        wait_idle(1'b1, 8'h41, acc, 1'b0);

        repeat (3) @(negedge clk_clk);
        chk("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
